// File: rtl/ceespu_pkg.sv
// Shared constants for the ceespu data-memory arbiter: bus widths and the
// bus-owner encoding used by the fairness tracker.
package ceespu_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W         = 32;
    localparam int BE_W           = 4;

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = OWN_IDLE,
        ST_CPU  = OWN_CPU,
        ST_DMA  = OWN_DMA
    } owner_e;

endpackage

// File: rtl/ceespu_arb_fairness.sv
// Tracks who owned the RAM last cycle and how long each master has been
// favoured, and tells the top level when the DMA must win a contended cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no access was issued last cycle
//   ST_CPU  | last cycle's access belonged to the CPU
//   ST_DMA  | last cycle's access belonged to the DMA master
module ceespu_arb_fairness
    import ceespu_pkg::*;
#(
    parameter int MAX_CPU_RUN = 8,
    parameter int DMA_BURST   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_grant,
    input  logic dma_grant,
    input  logic dma_req,
    output logic dma_priority
);

    owner_e     owner, owner_nxt;
    logic [7:0] starve_cnt, starve_nxt;
    logic [7:0] burst_cnt, burst_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= ST_IDLE;
            starve_cnt <= 8'd0;
            burst_cnt  <= 8'd0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    always_comb begin
        owner_nxt  = ST_IDLE;
        starve_nxt = starve_cnt;
        burst_nxt  = 8'd0;

        if (cpu_grant)
            owner_nxt = ST_CPU;
        else if (dma_grant)
            owner_nxt = ST_DMA;

        if (dma_grant || !dma_req)
            starve_nxt = 8'd0;
        else if (cpu_grant && (starve_cnt != 8'(MAX_CPU_RUN)))
            starve_nxt = starve_cnt + 8'd1;

        // A fresh DMA run counts from 1 so the limit means "grants issued".
        if (dma_grant) begin
            if (owner != ST_DMA)
                burst_nxt = 8'd1;
            else if (burst_cnt != 8'hFF)
                burst_nxt = burst_cnt + 8'd1;
            else
                burst_nxt = burst_cnt;
        end
    end

    assign dma_priority = (starve_cnt == 8'(MAX_CPU_RUN)) ||
                          ((owner == ST_DMA) && (burst_cnt < 8'(DMA_BURST)));

endmodule

// File: rtl/ceespu_dmem_arbiter.sv
// Shares one single-port synchronous RAM between the ceespu data port and a
// DMA/boot master: combinational command mux, registered response routing.
module ceespu_dmem_arbiter
    import ceespu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int MAX_CPU_RUN = 8,
    parameter int DMA_BURST   = 4
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_cpuE,
    input  logic [BE_W-1:0]   I_cpuWe,
    input  logic [ADDR_W-1:0] I_cpuAddress,
    input  logic [DATA_W-1:0] I_cpuWData,
    output logic              O_cpuBusy,
    output logic [DATA_W-1:0] O_cpuRData,
    input  logic              I_dmaReq,
    input  logic [BE_W-1:0]   I_dmaWe,
    input  logic [ADDR_W-1:0] I_dmaAddress,
    input  logic [DATA_W-1:0] I_dmaWData,
    output logic              O_dmaGnt,
    output logic [DATA_W-1:0] O_dmaRData,
    output logic              O_dmaValid,
    output logic              O_memE,
    output logic [BE_W-1:0]   O_memWe,
    output logic [ADDR_W-1:0] O_memAddress,
    output logic [DATA_W-1:0] O_memWData,
    input  logic [DATA_W-1:0] I_memRData
);

    logic dma_priority;
    logic cpu_grant;
    logic dma_grant;
    logic rd_cpu;
    logic rd_dma;

    // Reset gates the grants so nothing reaches the RAM while I_rst_n is low.
    assign cpu_grant = I_rst_n & I_cpuE & ~(I_dmaReq & dma_priority);
    assign dma_grant = I_rst_n & I_dmaReq & (~I_cpuE | dma_priority);

    ceespu_arb_fairness #(
        .MAX_CPU_RUN (MAX_CPU_RUN),
        .DMA_BURST   (DMA_BURST)
    ) u_fairness (
        .clk          (I_clk),
        .rst_n        (I_rst_n),
        .cpu_grant    (cpu_grant),
        .dma_grant    (dma_grant),
        .dma_req      (I_dmaReq),
        .dma_priority (dma_priority)
    );

    always_comb begin
        O_memE       = 1'b0;
        O_memWe      = '0;
        O_memAddress = '0;
        O_memWData   = '0;
        if (cpu_grant) begin
            O_memE       = 1'b1;
            O_memWe      = I_cpuWe;
            O_memAddress = I_cpuAddress;
            O_memWData   = I_cpuWData;
        end else if (dma_grant) begin
            O_memE       = 1'b1;
            O_memWe      = I_dmaWe;
            O_memAddress = I_dmaAddress;
            O_memWData   = I_dmaWData;
        end
    end

    assign O_cpuBusy = I_cpuE & ~cpu_grant;
    assign O_dmaGnt  = dma_grant;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_cpu <= 1'b0;
            rd_dma <= 1'b0;
        end else begin
            rd_cpu <= cpu_grant & (I_cpuWe == '0);
            rd_dma <= dma_grant & (I_dmaWe == '0);
        end
    end

    assign O_cpuRData = rd_cpu ? I_memRData : '0;
    assign O_dmaRData = rd_dma ? I_memRData : '0;
    assign O_dmaValid = rd_dma;

endmodule

// File: tb/tb_ceespu_dmem_arbiter.sv
// Directed bench for ceespu_dmem_arbiter with MAX_CPU_RUN=4, DMA_BURST=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ceespu_dmem_arbiter;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_cpuE;
    logic [3:0]  I_cpuWe;
    logic [15:0] I_cpuAddress;
    logic [31:0] I_cpuWData;
    logic        O_cpuBusy;
    logic [31:0] O_cpuRData;
    logic        I_dmaReq;
    logic [3:0]  I_dmaWe;
    logic [15:0] I_dmaAddress;
    logic [31:0] I_dmaWData;
    logic        O_dmaGnt;
    logic [31:0] O_dmaRData;
    logic        O_dmaValid;
    logic        O_memE;
    logic [3:0]  O_memWe;
    logic [15:0] O_memAddress;
    logic [31:0] O_memWData;
    logic [31:0] I_memRData;

    int n_cmp = 0;
    int n_err = 0;

    ceespu_dmem_arbiter #(
        .ADDR_W      (16),
        .MAX_CPU_RUN (4),
        .DMA_BURST   (2)
    ) dut (
        .I_clk        (I_clk),
        .I_rst_n      (I_rst_n),
        .I_cpuE       (I_cpuE),
        .I_cpuWe      (I_cpuWe),
        .I_cpuAddress (I_cpuAddress),
        .I_cpuWData   (I_cpuWData),
        .O_cpuBusy    (O_cpuBusy),
        .O_cpuRData   (O_cpuRData),
        .I_dmaReq     (I_dmaReq),
        .I_dmaWe      (I_dmaWe),
        .I_dmaAddress (I_dmaAddress),
        .I_dmaWData   (I_dmaWData),
        .O_dmaGnt     (O_dmaGnt),
        .O_dmaRData   (O_dmaRData),
        .O_dmaValid   (O_dmaValid),
        .O_memE       (O_memE),
        .O_memWe      (O_memWe),
        .O_memAddress (O_memAddress),
        .O_memWData   (O_memWData),
        .I_memRData   (I_memRData)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge I_clk);
    endtask

    initial begin
        I_rst_n = 1'b0;  I_cpuE = 1'b1;  I_cpuWe = 4'h0;  I_cpuAddress = 16'h0;
        I_cpuWData = 32'h0;  I_dmaReq = 1'b0;  I_dmaWe = 4'h0;  I_dmaAddress = 16'h0;
        I_dmaWData = 32'h0;  I_memRData = 32'h0;

        // While in reset the CPU sees a stall and the RAM stays disabled.
        #3;
        check("rst_busy", 32'(O_cpuBusy), 32'd1);
        check("rst_memE", 32'(O_memE), 32'd0);
        check("rst_dmaGnt", 32'(O_dmaGnt), 32'd0);
        check("rst_dmaValid", 32'(O_dmaValid), 32'd0);
        I_cpuE = 1'b0;
        sample();
        I_rst_n = 1'b1;
        tick();

        // CPU-only read
        I_cpuE = 1'b1;  I_cpuWe = 4'h0;  I_cpuAddress = 16'h0010;
        sample();
        check("cpu_rd_memE", 32'(O_memE), 32'd1);
        check("cpu_rd_busy", 32'(O_cpuBusy), 32'd0);
        check("cpu_rd_addr", 32'(O_memAddress), 32'h0010);
        check("cpu_rd_we", 32'(O_memWe), 32'h0);
        tick();
        I_cpuE = 1'b0;  I_memRData = 32'hDEADBEEF;
        sample();
        check("cpu_rd_data", O_cpuRData, 32'hDEADBEEF);
        check("cpu_rd_dmaValid", 32'(O_dmaValid), 32'd0);
        check("cpu_rd_dmaRData", O_dmaRData, 32'h0);
        check("cpu_rd_idle_memE", 32'(O_memE), 32'd0);
        tick();
        I_memRData = 32'h0;

        // DMA-only write
        I_dmaReq = 1'b1;  I_dmaWe = 4'hF;  I_dmaAddress = 16'h0100;  I_dmaWData = 32'h12345678;
        sample();
        check("dma_wr_gnt", 32'(O_dmaGnt), 32'd1);
        check("dma_wr_we", 32'(O_memWe), 32'hF);
        check("dma_wr_addr", 32'(O_memAddress), 32'h0100);
        check("dma_wr_data", O_memWData, 32'h12345678);
        check("dma_wr_busy", 32'(O_cpuBusy), 32'd0);
        tick();
        I_dmaReq = 1'b0;  I_dmaWe = 4'h0;  I_memRData = 32'hFFFFFFFF;
        sample();
        check("dma_wr_noValid", 32'(O_dmaValid), 32'd0);
        check("dma_wr_noRData", O_dmaRData, 32'h0);
        tick();
        I_memRData = 32'h0;

        // Continuous contention: CPU x4 then DMA x2, repeating.
        I_cpuE = 1'b1;  I_cpuWe = 4'h0;  I_cpuAddress = 16'h0040;
        I_dmaReq = 1'b1;  I_dmaWe = 4'h0;  I_dmaAddress = 16'h0200;
        for (int i = 0; i < 12; i++) begin
            sample();
            check($sformatf("cont_gnt[%0d]", i), 32'(O_dmaGnt), ((i % 6) >= 4) ? 32'd1 : 32'd0);
            check($sformatf("cont_busy[%0d]", i), 32'(O_cpuBusy), ((i % 6) >= 4) ? 32'd1 : 32'd0);
            tick();
        end
        I_cpuE = 1'b0;  I_dmaReq = 1'b0;
        sample();
        check("cont_idle_memE", 32'(O_memE), 32'd0);
        tick();

        // DMA alone is never throttled; a CPU arriving after a long run wins.
        I_dmaReq = 1'b1;  I_dmaWe = 4'hF;  I_dmaAddress = 16'h0300;  I_dmaWData = 32'h0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check($sformatf("solo_gnt[%0d]", i), 32'(O_dmaGnt), 32'd1);
            tick();
        end
        I_cpuE = 1'b1;  I_cpuWe = 4'h0;  I_cpuAddress = 16'h0050;
        sample();
        check("solo_cpu_busy", 32'(O_cpuBusy), 32'd0);
        check("solo_cpu_dmaGnt", 32'(O_dmaGnt), 32'd0);
        tick();
        I_cpuE = 1'b0;  I_dmaReq = 1'b0;  I_dmaWe = 4'h0;
        sample();
        tick();

        // Simultaneous first request after idle, both reads.
        I_cpuE = 1'b1;  I_cpuWe = 4'h0;  I_cpuAddress = 16'h0020;
        I_dmaReq = 1'b1;  I_dmaWe = 4'h0;  I_dmaAddress = 16'h0024;
        sample();
        check("sim_cpu_busy", 32'(O_cpuBusy), 32'd0);
        check("sim_dma_wait", 32'(O_dmaGnt), 32'd0);
        check("sim_cpu_addr", 32'(O_memAddress), 32'h0020);
        tick();
        I_cpuE = 1'b0;  I_memRData = 32'hCAFE0020;
        sample();
        check("sim_cpu_data", O_cpuRData, 32'hCAFE0020);
        check("sim_dma_gnt", 32'(O_dmaGnt), 32'd1);
        check("sim_dma_addr", 32'(O_memAddress), 32'h0024);
        check("sim_dma_notyet", 32'(O_dmaValid), 32'd0);
        tick();
        I_dmaReq = 1'b0;  I_memRData = 32'h0BAD0024;
        sample();
        check("sim_dma_valid", 32'(O_dmaValid), 32'd1);
        check("sim_dma_data", O_dmaRData, 32'h0BAD0024);
        check("sim_cpu_quiet", O_cpuRData, 32'h0);
        tick();
        I_memRData = 32'h0;
        sample();
        check("sim_dma_pulse_end", 32'(O_dmaValid), 32'd0);
        tick();

        // Reset asserted mid-burst with a DMA read outstanding.
        I_dmaReq = 1'b1;  I_dmaWe = 4'h0;  I_dmaAddress = 16'h0030;
        sample();
        check("rb_gnt", 32'(O_dmaGnt), 32'd1);
        tick();
        I_memRData = 32'h11112222;
        #1;
        check("rb_valid_before", 32'(O_dmaValid), 32'd1);
        I_rst_n = 1'b0;  I_cpuE = 1'b1;
        #1;
        check("rb_memE", 32'(O_memE), 32'd0);
        check("rb_dmaGnt", 32'(O_dmaGnt), 32'd0);
        check("rb_dmaValid", 32'(O_dmaValid), 32'd0);
        check("rb_dmaRData", O_dmaRData, 32'h0);
        check("rb_busy", 32'(O_cpuBusy), 32'd1);
        sample();
        I_cpuE = 1'b0;  I_dmaReq = 1'b0;  I_memRData = 32'h0;
        I_rst_n = 1'b1;
        tick();
        check("rb_after_valid", 32'(O_dmaValid), 32'd0);
        I_cpuE = 1'b1;  I_cpuWe = 4'h0;  I_cpuAddress = 16'h0060;
        I_dmaReq = 1'b1;  I_dmaWe = 4'h0;  I_dmaAddress = 16'h0064;
        sample();
        check("rb_after_cpu_busy", 32'(O_cpuBusy), 32'd0);
        check("rb_after_dmaGnt", 32'(O_dmaGnt), 32'd0);
        tick();
        I_cpuE = 1'b0;  I_dmaReq = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
